// File: rtl/axi_filter_err_slv.sv
// AXI error slave: answers rejected AW/AR with DECERR, drains W beats, returns len+1 R beats.
// Optional macro AXI_FILTER_ERR_SLV_PATTERN_EN fills R data with 32'hBADCAB1E instead of zeros.
module axi_filter_err_slv #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 7,
    parameter int unsigned AXI_USER_WIDTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      err_aw_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]   err_aw_id_i,
    input  logic [AXI_USER_WIDTH-1:0] err_aw_user_i,
    output logic                      err_aw_ready_o,
    input  logic                      w_valid_i,
    input  logic                      w_last_i,
    output logic                      w_ready_o,
    output logic                      b_valid_o,
    output logic [1:0]                b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   b_id_o,
    output logic [AXI_USER_WIDTH-1:0] b_user_o,
    input  logic                      b_ready_i,
    input  logic                      err_ar_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]   err_ar_id_i,
    input  logic [7:0]                err_ar_len_i,
    input  logic [AXI_USER_WIDTH-1:0] err_ar_user_i,
    output logic                      err_ar_ready_o,
    output logic                      r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   r_id_o,
    output logic [AXI_USER_WIDTH-1:0] r_user_o,
    input  logic                      r_ready_i
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DRAIN = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_FILTER_ERR_SLV_PATTERN_EN
    localparam int unsigned PAT_REPS = (AXI_DATA_WIDTH + 31) / 32;
    localparam logic [PAT_REPS*32-1:0] PAT_FULL = {PAT_REPS{32'hBADCAB1E}};
`endif

    logic                      live;
    logic [1:0]                w_state;
    logic [0:0]                r_state;
    logic [7:0]                beat_cnt;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q;
    logic [AXI_USER_WIDTH-1:0] aw_user_q;
    logic [AXI_ID_WIDTH-1:0]   ar_id_q;
    logic [AXI_USER_WIDTH-1:0] ar_user_q;

    // Holds the address readies low while in reset; they rise on the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign err_aw_ready_o = live && (w_state == W_IDLE);
    assign w_ready_o      = (w_state == W_DRAIN);
    assign b_valid_o      = (w_state == W_RESP);
    assign b_resp_o       = b_valid_o ? RESP_DECERR : 2'b00;
    assign b_id_o         = aw_id_q;
    assign b_user_o       = aw_user_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state   <= W_IDLE;
            aw_id_q   <= '0;
            aw_user_q <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (err_aw_valid_i && err_aw_ready_o) begin
                        aw_id_q   <= err_aw_id_i;
                        aw_user_q <= err_aw_user_i;
                        w_state   <= W_DRAIN;
                    end
                end
                W_DRAIN: begin
                    if (w_valid_i && w_last_i) w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_ready_i) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign err_ar_ready_o = live && (r_state == R_IDLE);
    assign r_valid_o      = (r_state == R_BURST);
    assign r_resp_o       = r_valid_o ? RESP_DECERR : 2'b00;
    assign r_last_o       = r_valid_o && (beat_cnt == 8'd0);
    assign r_id_o         = ar_id_q;
    assign r_user_o       = ar_user_q;

`ifdef AXI_FILTER_ERR_SLV_PATTERN_EN
    assign r_data_o = r_valid_o ? PAT_FULL[AXI_DATA_WIDTH-1:0] : '0;
`else
    assign r_data_o = '0;
`endif

    // Counter holds beats remaining after the current one; last beat leaves it at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= R_IDLE;
            beat_cnt  <= '0;
            ar_id_q   <= '0;
            ar_user_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (err_ar_valid_i && err_ar_ready_o) begin
                        ar_id_q   <= err_ar_id_i;
                        ar_user_q <= err_ar_user_i;
                        beat_cnt  <= err_ar_len_i;
                        r_state   <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_ready_i) begin
                        if (beat_cnt == 8'd0) r_state  <= R_IDLE;
                        else                  beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_filter_err_slv.md
AXI_FILTER_ERR_SLV -- requirements
Module: axi_filter_err_slv

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 64, giving the R data width in bits.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 7, giving the ID width in bits.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 4, giving the USER width in bits.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as below.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have the rejected-write address ports below.
- err_aw_valid_i  in  1  rejected AW present.
- err_aw_id_i  in  AXI_ID_WIDTH  AW ID.
- err_aw_user_i  in  AXI_USER_WIDTH  AW USER.
- err_aw_ready_o  out  1  AW accepted.
REQ-006 SHALL have the write data sink ports below.
- w_valid_i  in  1  W beat present.
- w_last_i  in  1  final W beat.
- w_ready_o  out  1  W beat accepted.
REQ-007 SHALL have the write response ports below.
- b_valid_o  out  1  B response valid.
- b_resp_o  out  2  B response code.
- b_id_o  out  AXI_ID_WIDTH  B ID.
- b_user_o  out  AXI_USER_WIDTH  B USER.
- b_ready_i  in  1  B response accepted.
REQ-008 SHALL have the rejected-read address ports below.
- err_ar_valid_i  in  1  rejected AR present.
- err_ar_id_i  in  AXI_ID_WIDTH  AR ID.
- err_ar_len_i  in  8  AR burst length minus one.
- err_ar_user_i  in  AXI_USER_WIDTH  AR USER.
- err_ar_ready_o  out  1  AR accepted.
REQ-009 SHALL have the read data ports below.
- r_valid_o  out  1  R beat valid.
- r_data_o  out  AXI_DATA_WIDTH  R data.
- r_resp_o  out  2  R response code.
- r_last_o  out  1  final R beat.
- r_id_o  out  AXI_ID_WIDTH  R ID.
- r_user_o  out  AXI_USER_WIDTH  R USER.
- r_ready_i  in  1  R beat accepted.

Function
REQ-010 SHALL run the write path and the read path as independent state machines; neither path SHALL stall the other.
REQ-011 Write FSM states: W_IDLE, W_DRAIN, W_RESP.
- W_IDLE: err_aw_ready_o=1; on an AW handshake, register ID/USER and go to W_DRAIN.
- W_DRAIN: w_ready_o=1; every beat is discarded; a handshake with w_last_i=1 goes to W_RESP.
- W_RESP: b_valid_o=1, b_resp_o=2'b11 (DECERR); on a b_ready_i handshake, go to W_IDLE.
REQ-012 SHALL hold err_aw_ready_o=0 outside W_IDLE and w_ready_o=0 outside W_DRAIN.
- As a result, at most one write is outstanding.
- W beats arriving before the AW SHALL NOT be accepted.
REQ-013 Read FSM states: R_IDLE, R_BURST.
- R_IDLE: err_ar_ready_o=1; on an AR handshake, register ID/USER, load the beat counter with err_ar_len_i, and go to R_BURST.
- R_BURST: r_valid_o=1, r_resp_o=2'b11.
- r_last_o=1 exactly when the counter equals 0.
- Each r_ready_i handshake decrements the counter.
- A handshake with r_last_o=1 goes to R_IDLE.
REQ-014 SHALL emit exactly err_ar_len_i+1 R beats: len=0 gives one beat with last set; len=255 gives 256 beats.
REQ-015 The 8-bit counter SHALL never wrap; it is only decremented while nonzero.
REQ-016 Latency:
- First R beat valid one cycle after the AR handshake.
- B valid one cycle after the last W handshake.
- Next AR/AW accepted one cycle after the final R/B handshake; no back-to-back acceptance in the same cycle.
REQ-017 While valid is held and ready is low, r_*/b_* outputs SHALL stay stable.
REQ-018 b_id_o/b_user_o and r_id_o/r_user_o SHALL equal the values registered at address acceptance.

Reset
REQ-019 Assertion of i_rst_n=0 SHALL asynchronously force both FSMs to IDLE and the beat counter to 0.
REQ-020 Output values in reset:
- err_aw_ready_o=0, err_ar_ready_o=0, w_ready_o=0, b_valid_o=0, r_valid_o=0, r_last_o=0.
- All data/ID/USER/resp outputs=0.
REQ-021 After deassertion, the ready outputs SHALL rise on the first clock edge.
REQ-022 Reset mid-burst SHALL abandon the transaction with no further beats.

Configuration
REQ-023 AXI_FILTER_ERR_SLV_PATTERN_EN defined: r_data_o SHALL carry 32'hBADCAB1E replicated across AXI_DATA_WIDTH during R_BURST.
- Undefined: r_data_o SHALL be all zeros.
- Control behaviour is identical with or without the macro.

Verification
REQ-024 AR id=5, len=3, r_ready_i=1 -> 4 R beats, resp=3, id=5, last on beat 4 only, err_ar_ready_o=1 the next cycle.
REQ-025 AW id=2, then 3 W beats with last on the 3rd, b_ready_i low for 2 cycles -> one B beat, resp=3, id=2, held stable until accepted.
REQ-026 AR len=0 and AW in the same cycle -> both accepted; R (single beat, last=1) and B proceed concurrently.
REQ-027 AR len=255 with r_ready_i toggled randomly -> exactly 256 beats and a single last.
REQ-028 Reset asserted during beat 2 of a len=7 burst -> r_valid_o=0 immediately; after release, a new AR is accepted and its full burst is returned.
REQ-029 Run with and without the macro -> r_data_o is 64'hBADCAB1EBADCAB1E versus 0, with identical handshake traces.
